// File: rtl/pic_control_logic_n.sv
// rtl/pic_control_logic_n.sv - IRR/ISR/IMR, priority resolution, INTA handshake and OCW2 commands for a NUM_IRQ-input PIC
// Optional feature: define PIC_ROTATE_EN to enable rotating-priority OCW2 commands (101, 111, 110).
module pic_control_logic_n #(
   parameter  int NUM_IRQ  = 8,
   localparam int ID_WIDTH = $clog2(NUM_IRQ)
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic [NUM_IRQ-1:0] interrupt_request,
   input  logic [7:0]         internal_data_bus,
   input  logic               write_initial_command_word_1,
   input  logic               write_initial_command_word_2,
   input  logic               write_interrupt_mask,
   input  logic [NUM_IRQ-1:0] mask_data,
   input  logic               write_operation_control_word_2,
   input  logic               interrupt_acknowledge_n,
   output logic               interrupt_to_cpu,
   output logic [7:0]         vector_out,
   output logic               vector_valid,
   output logic [NUM_IRQ-1:0] interrupt_request_register,
   output logic [NUM_IRQ-1:0] in_service_register,
   output logic [NUM_IRQ-1:0] interrupt_mask
);

   typedef enum logic [1:0] {
      ST_READY = 2'd0,
      ST_ACK1  = 2'd1,
      ST_ACK2  = 2'd2
   } state_t;

   // Lowest-priority level when IR0 is highest; also the spurious acknowledge id.
   localparam logic [ID_WIDTH-1:0] LAST_LEVEL = ID_WIDTH'(NUM_IRQ - 1);

   state_t               state_q, state_d;
   logic [NUM_IRQ-1:0]   irr_q, irr_d;
   logic [NUM_IRQ-1:0]   isr_q, isr_d;
   logic [NUM_IRQ-1:0]   imr_q, imr_d;
   logic [NUM_IRQ-1:0]   ir_prev_q, ir_prev_d;
   logic [ID_WIDTH-1:0]  priority_base_q, priority_base_d;
   logic [ID_WIDTH-1:0]  ack_id_q, ack_id_d;
   logic [7:0]           vector_base_q, vector_base_d;
   logic [7:0]           vector_out_q, vector_out_d;
   logic                 level_mode_q, level_mode_d;
   logic                 auto_eoi_q, auto_eoi_d;
   logic                 spurious_q, spurious_d;
   logic                 inta_n_prev_q, inta_n_prev_d;
   logic                 int_q, int_d;
   logic                 vector_valid_q, vector_valid_d;

   logic                 inta_fall;
   logic                 inta_rise;
   logic                 pend_found;
   logic [ID_WIDTH-1:0]  pend_lvl;
   logic [ID_WIDTH-1:0]  pend_rank;
   logic                 isr_found;
   logic [ID_WIDTH-1:0]  isr_lvl;
   logic [ID_WIDTH-1:0]  isr_rank;
   logic [2:0]           ocw2_cmd;
   logic [ID_WIDTH-1:0]  ocw2_level;
   logic                 ocw2_level_ok;
   logic [NUM_IRQ-1:0]   irq_edges;
   logic [NUM_IRQ-1:0]   ack_set;
   logic [NUM_IRQ-1:0]   eoi_clear;
   logic [NUM_IRQ-1:0]   aeoi_clear;

   // Scan ranks from lowest to highest so the highest-rank set bit is the last one written.
   function automatic void resolve(
      input  logic [NUM_IRQ-1:0]  vec,
      input  logic [ID_WIDTH-1:0] base,
      output logic                found,
      output logic [ID_WIDTH-1:0] level,
      output logic [ID_WIDTH-1:0] rank
   );
      int                  idx;
      logic [ID_WIDTH-1:0] idx_l;
      found = 1'b0;
      level = '0;
      rank  = '0;
      for (int k = NUM_IRQ - 1; k >= 0; k--) begin
         idx = int'(base) + 1 + k;
         if (idx >= NUM_IRQ) begin
            idx = idx - NUM_IRQ;
         end
         idx_l = idx[ID_WIDTH-1:0];
         if (vec[idx_l]) begin
            found = 1'b1;
            level = idx_l;
            rank  = k[ID_WIDTH-1:0];
         end
      end
   endfunction

   function automatic logic [NUM_IRQ-1:0] onehot(input logic [ID_WIDTH-1:0] lvl);
      logic [NUM_IRQ-1:0] v;
      v      = '0;
      v[lvl] = 1'b1;
      return v;
   endfunction

   assign inta_fall     = inta_n_prev_q & ~interrupt_acknowledge_n;
   assign inta_rise     = ~inta_n_prev_q & interrupt_acknowledge_n;
   assign ocw2_cmd      = internal_data_bus[7:5];
   assign ocw2_level    = internal_data_bus[ID_WIDTH-1:0];
   assign ocw2_level_ok = ({27'd0, internal_data_bus[4:0]} < 32'(NUM_IRQ));
   assign irq_edges     = interrupt_request & ~ir_prev_q;

   // State register plus all datapath flops.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q         <= ST_READY;
         irr_q           <= '0;
         isr_q           <= '0;
         imr_q           <= '0;
         ir_prev_q       <= '0;
         priority_base_q <= LAST_LEVEL;
         ack_id_q        <= '0;
         vector_base_q   <= '0;
         vector_out_q    <= '0;
         level_mode_q    <= 1'b0;
         auto_eoi_q      <= 1'b0;
         spurious_q      <= 1'b0;
         inta_n_prev_q   <= 1'b1;
         int_q           <= 1'b0;
         vector_valid_q  <= 1'b0;
      end else begin
         state_q         <= state_d;
         irr_q           <= irr_d;
         isr_q           <= isr_d;
         imr_q           <= imr_d;
         ir_prev_q       <= ir_prev_d;
         priority_base_q <= priority_base_d;
         ack_id_q        <= ack_id_d;
         vector_base_q   <= vector_base_d;
         vector_out_q    <= vector_out_d;
         level_mode_q    <= level_mode_d;
         auto_eoi_q      <= auto_eoi_d;
         spurious_q      <= spurious_d;
         inta_n_prev_q   <= inta_n_prev_d;
         int_q           <= int_d;
         vector_valid_q  <= vector_valid_d;
      end
   end

   // Handshake next state; ICW1 always returns the sequence to READY.
   always_comb begin
      state_d = state_q;
      if (write_initial_command_word_1) begin
         state_d = ST_READY;
      end else begin
         case (state_q)
            ST_READY: if (inta_fall) state_d = ST_ACK1;
            ST_ACK1:  if (inta_rise) state_d = ST_ACK2;
            ST_ACK2:  if (inta_rise) state_d = ST_READY;
            default:  state_d = ST_READY;
         endcase
      end
   end

   // Highest-rank pending (unmasked, old IMR) and in-service levels under the current rotation.
   always_comb begin
      resolve(irr_q & ~imr_q, priority_base_q, pend_found, pend_lvl, pend_rank);
      resolve(isr_q, priority_base_q, isr_found, isr_lvl, isr_rank);
   end

   // Register updates: commands, acknowledge side effects, vector drive and the INT output.
   always_comb begin
      ack_set         = '0;
      eoi_clear       = '0;
      aeoi_clear      = '0;
      imr_d           = imr_q;
      priority_base_d = priority_base_q;
      vector_base_d   = vector_base_q;
      level_mode_d    = level_mode_q;
      auto_eoi_d      = auto_eoi_q;
      ack_id_d        = ack_id_q;
      spurious_d      = spurious_q;
      vector_valid_d  = vector_valid_q;
      vector_out_d    = vector_out_q;
      ir_prev_d       = interrupt_request;
      inta_n_prev_d   = interrupt_acknowledge_n;

      if (write_initial_command_word_2) begin
         vector_base_d = internal_data_bus;
      end
      if (write_interrupt_mask) begin
         imr_d = mask_data;
      end

      // A level field beyond the implemented range voids the whole command.
      if (write_operation_control_word_2 && ocw2_level_ok) begin
         case (ocw2_cmd)
            3'b001: if (isr_found) eoi_clear = onehot(isr_lvl);
            3'b011: eoi_clear = onehot(ocw2_level);
`ifdef PIC_ROTATE_EN
            3'b101: begin
               if (isr_found) begin
                  eoi_clear       = onehot(isr_lvl);
                  priority_base_d = isr_lvl;
               end
            end
            3'b111: begin
               eoi_clear       = onehot(ocw2_level);
               priority_base_d = ocw2_level;
            end
            3'b110: priority_base_d = ocw2_level;
`else
            3'b101: if (isr_found) eoi_clear = onehot(isr_lvl);
            3'b111: eoi_clear = onehot(ocw2_level);
`endif
            default: ;
         endcase
      end

      case (state_q)
         ST_READY: begin
            if (inta_fall) begin
               if (pend_found) begin
                  ack_id_d   = pend_lvl;
                  spurious_d = 1'b0;
                  ack_set    = onehot(pend_lvl);
               end else begin
                  ack_id_d   = LAST_LEVEL;
                  spurious_d = 1'b1;
               end
            end
         end
         ST_ACK2: begin
            if (inta_fall) begin
               vector_valid_d = 1'b1;
               vector_out_d   = vector_base_q + 8'(ack_id_q);
            end else if (inta_rise) begin
               vector_valid_d = 1'b0;
               vector_out_d   = '0;
               if (auto_eoi_q && !spurious_q) begin
                  aeoi_clear = onehot(ack_id_q);
               end
            end
         end
         default: ;
      endcase

      // The acknowledge set is applied last so it beats a same-cycle EOI on that bit.
      isr_d = (isr_q & ~eoi_clear & ~aeoi_clear) | ack_set;
      if (level_mode_q) begin
         irr_d = interrupt_request;
      end else begin
         irr_d = (irr_q & ~ack_set) | irq_edges;
      end

      int_d = (state_d == ST_READY) && pend_found && (!isr_found || (pend_rank < isr_rank));

      if (write_initial_command_word_1) begin
         irr_d           = '0;
         isr_d           = '0;
         imr_d           = '0;
         priority_base_d = LAST_LEVEL;
         vector_base_d   = vector_base_q;
         level_mode_d    = internal_data_bus[3];
         auto_eoi_d      = internal_data_bus[1];
         ack_id_d        = '0;
         spurious_d      = 1'b0;
         vector_valid_d  = 1'b0;
         vector_out_d    = '0;
         int_d           = 1'b0;
      end
   end

   assign interrupt_to_cpu           = int_q;
   assign vector_out                 = vector_out_q;
   assign vector_valid               = vector_valid_q;
   assign interrupt_request_register = irr_q;
   assign in_service_register        = isr_q;
   assign interrupt_mask             = imr_q;

endmodule
